// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
interface imem_loader_if #(
  parameter int AW = 5
) ();
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a checksum-protected program image into instruction memory and
// holds the core in reset until a complete, verified image is in place.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  input  logic         reload,
  output logic         core_run,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  localparam logic [7:0] DEPTH8 = 8'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    n_q, n_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [7:0]    widx_q, widx_d;
  logic [7:0]    acc_q, acc_d;
  logic [23:0]   word_q, word_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          run_q, run_d;
  logic          ready;
  logic          fire;

  always_comb begin
    ready = !rst && (state_q == IDLE || state_q == LOAD || state_q == CHECK);
    fire  = ready && bus.in_valid;
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    bidx_d    = bidx_q;
    widx_d    = widx_q;
    acc_d     = acc_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    error_d   = error_q;
    run_d     = run_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (bus.in_data == 8'd0 || bus.in_data > DEPTH8) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            n_d     = bus.in_data;
            bidx_d  = '0;
            widx_d  = '0;
            acc_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (fire) begin
          acc_d  = acc_q ^ bus.in_data;
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: word_d[7:0]   = bus.in_data;
            2'd1: word_d[15:8]  = bus.in_data;
            2'd2: word_d[23:16] = bus.in_data;
            default: begin
              // The top lane goes straight into the write register, so the
              // word reaches memory in the cycle after its last byte.
              wr_en_d   = 1'b1;
              wr_addr_d = AW'(widx_q);
              wr_data_d = {bus.in_data, word_q};
              widx_d    = widx_q + 8'd1;
              if (widx_q == n_q - 8'd1) state_d = CHECK;
            end
          endcase
        end
      end
      CHECK: begin
        if (fire) begin
          if (bus.in_data == acc_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            run_d   = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (reload) begin
          state_d = IDLE;
          done_d  = 1'b0;
          run_d   = 1'b0;
        end
      end
      ERR: begin
        if (reload) begin
          state_d = IDLE;
          error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      bidx_q    <= '0;
      widx_q    <= '0;
      acc_q     <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      bidx_q    <= bidx_d;
      widx_q    <= widx_d;
      acc_q     <= acc_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      run_q     <= run_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign core_run     = run_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes
// plus a table of generated frames and hand-written corner sequences.
module tb_imem_loader;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0] n;
    int         nw;
    logic       corrupt;
    int         maxgap;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic core_run;
  logic done;
  logic error;

  int checks = 0;
  int fails  = 0;
  int n_wr   = 0;
  int n0;
  wr_t exp_q[$];
  logic [31:0] words[256];
  logic [7:0] f1[10];
  vec_t vecs[7];

  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reload(reload),
    .core_run(core_run), .done(done), .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int waits = 0;
    int unsigned g;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for byte 0x%02h, expected 1", b);
    end
    tick();
    bus.in_valid = 1'b0;
    g = $urandom_range(maxgap, 0);
    repeat (g) tick();
  endtask

  task automatic send_frame(input logic [7:0] n, input int nw, input logic corrupt, input int maxgap);
    logic [7:0] ck = 8'h00;
    logic [7:0] b;
    send_byte(n, maxgap);
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back('{AW'(w), words[w]});
      for (int k = 0; k < 4; k++) begin
        b  = words[w][8*k +: 8];
        ck = ck ^ b;
        send_byte(b, maxgap);
      end
    end
    if (nw > 0) send_byte(ck ^ {7'b0, corrupt}, maxgap);
  endtask

  task automatic chk_status(input string tag, input logic e_done, input logic e_err, input logic e_ready);
    @(negedge clk);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_error"}, error, e_err);
    chk({tag, "_core_run"}, core_run, e_done);
    chk({tag, "_in_ready"}, bus.in_ready, e_ready);
    tick();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    wr_t e;
    fork
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      forever begin
        @(negedge clk);
        if (bus.wr_en) begin
          n_wr++;
          chk("wr_core_held", core_run, 0);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL wr_unexpected: write addr %0d data 0x%08h, expected no write",
                     bus.wr_addr, bus.wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.wr_addr, e.addr);
            chk("wr_data", bus.wr_data, e.data);
          end
        end
      end
    join_none

    vecs[0] = '{8'd1,   1,  1'b0, 0, 1'b1, 1'b0};
    vecs[1] = '{8'd32,  32, 1'b0, 3, 1'b1, 1'b0};
    vecs[2] = '{8'd5,   5,  1'b1, 1, 1'b0, 1'b1};
    vecs[3] = '{8'd0,   0,  1'b0, 0, 1'b0, 1'b1};
    vecs[4] = '{8'd33,  0,  1'b0, 0, 1'b0, 1'b1};
    vecs[5] = '{8'd255, 0,  1'b0, 0, 1'b0, 1'b1};
    vecs[6] = '{8'd32,  32, 1'b0, 0, 1'b1, 1'b0};
    f1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h42};

    rst = 1'b1;
    reload = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready_idle", bus.in_ready, 1);
    tick();

    // Nominal 2-word load, with a reload pulse in LOAD that must be ignored
    n0 = n_wr;
    exp_q.push_back('{AW'(0), 32'h0000_0000});
    exp_q.push_back('{AW'(1), 32'h0050_0113});
    for (int i = 0; i < 10; i++) begin
      send_byte(f1[i], 0);
      if (i == 4) do_reload();
    end
    chk_status("t1", 1'b1, 1'b0, 1'b0);
    chk("t1_writes", n_wr - n0, 2);

    // Reload from DONE with a byte already presented
    reload = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h01;
    tick();
    reload = 1'b0;
    @(negedge clk);
    chk("t6_core_run_fall", core_run, 0);
    chk("t6_in_ready_idle", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    n0 = n_wr;
    exp_q.push_back('{AW'(0), 32'hDDCC_BBAA});
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h00, 0);
    chk_status("t6", 1'b1, 1'b0, 1'b0);
    chk("t6_writes", n_wr - n0, 1);
    do_reload();

    // Checksum mismatch
    n0 = n_wr;
    exp_q.push_back('{AW'(0), 32'h0000_0000});
    exp_q.push_back('{AW'(1), 32'h0050_0113});
    for (int i = 0; i < 9; i++) send_byte(f1[i], 0);
    send_byte(8'h43, 0);
    chk_status("t2", 1'b0, 1'b1, 1'b0);
    chk("t2_writes", n_wr - n0, 2);
    do_reload();
    chk_status("t2_reload", 1'b0, 1'b0, 1'b1);

    // Bad counts
    n0 = n_wr;
    send_byte(8'h00, 0);
    chk_status("t3_zero", 1'b0, 1'b1, 1'b0);
    do_reload();
    send_byte(8'h21, 0);
    chk_status("t3_over", 1'b0, 1'b1, 1'b0);
    chk("t3_writes", n_wr - n0, 0);
    do_reload();

    // Reset after byte 6: only word 0 is written
    n0 = n_wr;
    exp_q.push_back('{AW'(0), 32'h0000_0000});
    for (int i = 0; i < 6; i++) send_byte(f1[i], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_status("t5_rst", 1'b0, 1'b0, 1'b1);
    chk("t5_partial_writes", n_wr - n0, 1);
    n0 = n_wr;
    exp_q.push_back('{AW'(0), 32'h0000_0000});
    exp_q.push_back('{AW'(1), 32'h0050_0113});
    for (int i = 0; i < 10; i++) send_byte(f1[i], 0);
    chk_status("t5", 1'b1, 1'b0, 1'b0);
    chk("t5_writes", n_wr - n0, 2);
    do_reload();

    // Generated frames
    for (int v = 0; v < 7; v++) begin
      for (int w = 0; w < 256; w++) words[w] = $urandom;
      n0 = n_wr;
      send_frame(vecs[v].n, vecs[v].nw, vecs[v].corrupt, vecs[v].maxgap);
      chk_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, 1'b0);
      chk($sformatf("vec%0d_writes", v), n_wr - n0, vecs[v].nw);
      do_reload();
      chk_status($sformatf("vec%0d_reload", v), 1'b0, 1'b0, 1'b1);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writes a program image into the core's 32-bit instruction memory from a host byte stream, and holds the core in reset until a complete, checksum-verified image is in place. It sits between the host link and the instruction-memory write port; its `core_run` output drives the core's active-low `rst`. The fetch stage reads instruction memory; this block is that memory's writer.

## Interface

**Parameters**
- `DEPTH`, default 32: instruction memory size in words. Legal range is 1..255.
- `AW`, default 5: word-address width. Must satisfy 2^AW ≥ DEPTH.

**Ports**
- `clk`  in  1: single clock for the block.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: host byte.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: the loader accepts a byte this cycle.
- `reload`  in  1: single-cycle pulse that starts a new load. Honoured only in DONE or ERR.
- `wr_en`  out  1: instruction memory write strobe, one cycle wide.
- `wr_addr`  out  AW: word address for the write.
- `wr_data`  out  32: word to write.
- `core_run`  out  1: 1 means the core is released. Connect directly to the core's active-low `rst`.
- `done`  out  1: image loaded and checksum matched.
- `error`  out  1: bad word count or checksum mismatch.

## Operation

**Handshake**
- A byte transfers on any cycle where `in_valid & in_ready` is 1.
- `in_ready = !rst && state ∈ {IDLE, LOAD, CHECK}`.
- Idle cycles between bytes (`in_valid` low) are legal in every state.

**Frame format**
- Byte 1: word count N.
- Next 4·N bytes: data words, little-endian (byte 0 → `wr_data[7:0]`).
- Last byte: checksum, equal to the XOR of all 4·N data bytes. The count byte is not included.

**States**
- **IDLE**: waits for the count byte.
  - N == 0 or N > DEPTH → ERR.
  - Otherwise: latch N, clear the byte index, word index and checksum accumulator, then go to LOAD.
- **LOAD**: each accepted byte is shifted into the word register at lane (byte index mod 4) and XORed into the accumulator.
  - On the 4th byte of a word, a write is issued (see Timing) and the word index increments.
  - After word N−1 completes → CHECK.
- **CHECK**: accepts one byte.
  - Byte equals the accumulator → DONE.
  - Otherwise → ERR.
- **DONE**: `done=1`, `core_run=1`, `in_ready=0`.
  - `reload` → IDLE, and `core_run` drops in that same transition.
- **ERR**: `error=1`, `core_run=0`, `in_ready=0`.
  - `reload` → IDLE.

**Memory writes**
- Writes are issued whatever the eventual checksum result. A failed checksum leaves partial or corrupt contents in memory, but the core stays held in reset.
- Addresses run 0..N−1. The word index never wraps, because N ≤ DEPTH is checked in IDLE.

## Timing

**Reset values**
- State is IDLE.
- `wr_en`, `wr_addr`, `wr_data`, `core_run`, `done` and `error` are all 0.
- Byte index, word index, N and the accumulator are all 0.
- Memory contents are not touched.

**Write latency**
- `wr_en`, `wr_addr` and `wr_data` are registered.
- `wr_en` is high for exactly the one cycle after the 4th byte of a word is accepted, with `wr_addr` = word index and `wr_data` = assembled word.
- `wr_addr` and `wr_data` hold their values between writes.

**Status outputs**
- `done`, `error` and `core_run` are registered and take their new values in the cycle after the deciding byte is accepted.
- The last data write (cycle after the last data byte) is therefore always at least one cycle before `core_run` rises.

**Boundary conditions**
- **Reset mid-load:** the loader returns to IDLE next cycle, `core_run=0`, and any partially assembled word is discarded with no write.
- **`reload` in IDLE, LOAD or CHECK:** ignored, with no effect on state or counters.
- **`reload` and `in_valid` both high in DONE or ERR:** no byte transfers (`in_ready=0`). The next cycle is in IDLE, and that is when the first byte can be accepted.
- **Back-to-back bytes:** accepted at one byte per cycle throughout.
- **`in_data` while `in_ready=0`:** ignored.

## Test plan

1. **Nominal 2-word load.** After reset, send 02, 00 00 00 00, 13 01 50 00, 42.
   - Writes: addr 0 ← 0x00000000, then addr 1 ← 0x00500113.
   - Then `done=1`, `core_run=1`, `error=0`, `in_ready=0`.
2. **Checksum mismatch.** Same frame with final byte 43.
   - Both writes still occur.
   - `error=1`, `core_run=0`, `done=0`.
   - A `reload` pulse returns the block to IDLE with `in_ready=1`.
3. **Bad count.** Send byte 00 → ERR next cycle with no writes. After `reload`, send byte 21 (33 > DEPTH) → ERR with no writes.
4. **Gaps and full depth.** Send 32 words with a random 0–3-cycle `in_valid` gap between bytes.
   - Exactly 32 `wr_en` pulses at addresses 0..31, with data matching.
   - Correct checksum → DONE.
5. **Reset mid-load.** Assert `rst` for one cycle after byte 6 of frame 1.
   - Only word 0 is written; no write for the partial word.
   - The block then accepts a fresh frame 1 and reaches DONE.
6. **Reload from DONE.** After test 1, pulse `reload` with `in_valid=1` and `in_data=01` held.
   - `core_run` falls the next cycle.
   - The byte is accepted one cycle later, in IDLE, as the count (N=1).
   - Complete the frame with AA BB CC DD, 00 → write addr 0 ← 0xDDCCBBAA, then DONE.
